// File: rtl/axil_mmio_dpi_bridge.sv
// axil_mmio_dpi_bridge: AXI4-Lite slave that forwards each accepted read or
// write to the device model through mmio_read / mmio_write. Read and write
// channels run independently, each with a single outstanding transaction,
// a programmable response latency, byte-lane steering and error responses.
//
// Optional feature: define MMIO_DPI_RANGE_CHECK_EN to reject any access
// outside [RANGE_BASE, RANGE_BASE+RANGE_SIZE) with DECERR and no model call.
//
// mmio_dpi_pkg below is the in-tree device-model endpoint. The Verilator
// harness binds these two entry points to its C-side model; in-tree they
// keep a call log and serve read data from a queue so the bridge can be
// exercised standalone.

package mmio_dpi_pkg;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    int unsigned len;
    logic [31:0] data;
  } mmio_call_t;

  mmio_call_t  call_log[$];
  logic [31:0] read_data_q[$];

  function automatic logic [31:0] mmio_read(input logic [63:0] addr, input int unsigned len);
    logic [31:0] v;
    if (read_data_q.size() > 0) v = read_data_q.pop_front();
    else v = 32'h0;
    call_log.push_back('{1'b0, addr, len, v});
    return v;
  endfunction

  function automatic void mmio_write(input logic [63:0] addr, input int unsigned len,
                                     input logic [31:0] data);
    call_log.push_back('{1'b1, addr, len, data});
  endfunction

endpackage

module axil_mmio_dpi_bridge #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          RD_LAT     = 1,
  parameter int          WR_LAT     = 1,
  parameter logic [31:0] RANGE_BASE = 32'h1000_0000,
  parameter logic [31:0] RANGE_SIZE = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   arAddr,
  input  logic [2:0]          arSize,
  input  logic                arValid,
  output logic                arReady,
  output logic [DATA_W-1:0]   rData,
  output logic [1:0]          rResp,
  output logic                rValid,
  input  logic                rReady,
  input  logic [ADDR_W-1:0]   awAddr,
  input  logic                awValid,
  output logic                awReady,
  input  logic [DATA_W-1:0]   wData,
  input  logic [DATA_W/8-1:0] wStrb,
  input  logic                wValid,
  output logic                wReady,
  output logic [1:0]          bResp,
  output logic                bValid,
  input  logic                bReady
);

  import mmio_dpi_pkg::*;

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANE_BITS = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  rd_state_t         rd_state;
  logic [3:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_size;
  logic [1:0]        rd_code;

  wr_state_t         wr_state;
  logic [3:0]        wr_cnt;
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  logic ar_take;
  logic aw_take;
  logic w_take;

  assign ar_take = arValid && arReady;
  assign aw_take = awValid && awReady;
  assign w_take  = wValid && wReady;

  // Window test done in 64 bits so BASE+SIZE cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    logic [63:0] a;
    a = 64'(addr);
    return (a >= 64'(RANGE_BASE)) && (a < 64'(RANGE_BASE) + 64'(RANGE_SIZE));
  endfunction

  // Keeps only the low len bytes of a model word (len is 1..4).
  function automatic logic [31:0] lane_mask(input int unsigned len);
    return 32'((33'd1 << (8 * len)) - 33'd1);
  endfunction

  // Response code for a read, decided once at the AR handshake.
  function automatic logic [1:0] rd_check(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic [2:0] size_mask;
`ifdef MMIO_DPI_RANGE_CHECK_EN
    if (!in_range(addr)) return RESP_DECERR;
`endif
    if (32'(size) > LANE_BITS) return RESP_SLVERR;
    size_mask = 3'((4'd1 << size) - 4'd1);
    if ((addr[2:0] & size_mask) != 3'd0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Issues the model read(s) for a legal access and steers bytes onto the bus.
  function automatic logic [DATA_W-1:0] do_read(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic [63:0] acc;
    logic [31:0] lo;
    logic [31:0] hi;
    int unsigned len;
    if (DATA_W == 64 && size == 3'd3) begin
      lo  = mmio_read(64'(addr), 4);
      hi  = mmio_read(64'(addr) + 64'd4, 4);
      acc = {hi, lo};
    end else begin
      len = 32'd1 << size;
      lo  = mmio_read(64'(addr), len) & lane_mask(len);
      acc = 64'(lo) << {addr[LANE_BITS-1:0], 3'b000};
    end
    return DATA_W'(acc);
  endfunction

  // Validates the strobe pattern, issues the model write(s), returns bResp.
  function automatic logic [1:0] do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                          input logic [STRB_W-1:0] strb);
    int unsigned       cnt;
    int unsigned       low;
    logic              found;
    logic              legal;
    logic [15:0]       run;
    logic [ADDR_W-1:0] base;
    logic [63:0]       shifted;
    cnt   = 0;
    low   = 0;
    found = 1'b0;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        cnt++;
        if (!found) begin
          low   = i;
          found = 1'b1;
        end
      end
    end
    // A legal pattern is a single run of 2^k bytes starting on a 2^k boundary.
    run   = 16'(((17'd1 << cnt) - 17'd1) << low);
    legal = (cnt == 1 || cnt == 2 || cnt == 4 || (cnt == 8 && DATA_W == 64)) &&
            ((low & (cnt - 1)) == 0) && (16'(strb) == run);
`ifdef MMIO_DPI_RANGE_CHECK_EN
    if (!in_range(addr)) return RESP_DECERR;
`endif
    if (!legal) return RESP_SLVERR;
    base    = addr & ~ADDR_W'(STRB_W - 1);
    shifted = 64'(data) >> (8 * low);
    if (cnt == 8) begin
      mmio_write(64'(base), 4, shifted[31:0]);
      mmio_write(64'(base) + 64'd4, 4, shifted[63:32]);
    end else begin
      mmio_write(64'(base + ADDR_W'(low)), cnt, shifted[31:0] & lane_mask(cnt));
    end
    return RESP_OKAY;
  endfunction

  // Both channel FSMs live in one block, write section first, so that a
  // write call always precedes a read call landing on the same edge.
  // NOTE: state updates use <= so every register samples pre-edge values;
  // the model calls inside the right-hand sides still run in statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      awReady  <= 1'b0;
      wReady   <= 1'b0;
      bValid   <= 1'b0;
      bResp    <= RESP_OKAY;
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_addr  <= '0;
      rd_size  <= '0;
      rd_code  <= RESP_OKAY;
      arReady  <= 1'b0;
      rValid   <= 1'b0;
      rData    <= '0;
      rResp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_take) begin
            wr_addr <= awAddr;
            aw_full <= 1'b1;
          end
          if (w_take) begin
            wr_data <= wData;
            wr_strb <= wStrb;
            w_full  <= 1'b1;
          end
          awReady <= !(aw_full || aw_take);
          wReady  <= !(w_full || w_take);
          if ((aw_full || aw_take) && (w_full || w_take)) begin
            wr_state <= W_WAIT;
            wr_cnt   <= 4'(WR_LAT - 1);
          end
        end
        W_WAIT: begin
          if (wr_cnt == 4'd0) begin
            wr_state <= W_RESP;
            bValid   <= 1'b1;
            bResp    <= do_write(wr_addr, wr_data, wr_strb);
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bReady) begin
            wr_state <= W_IDLE;
            bValid   <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            awReady  <= 1'b1;
            wReady   <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase

      case (rd_state)
        R_IDLE: begin
          arReady <= !ar_take;
          if (ar_take) begin
            rd_addr  <= arAddr;
            rd_size  <= arSize;
            rd_code  <= rd_check(arAddr, arSize);
            rd_cnt   <= 4'(RD_LAT - 1);
            rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd0) begin
            rd_state <= R_RESP;
            rValid   <= 1'b1;
            rResp    <= rd_code;
            if (rd_code == RESP_OKAY) rData <= do_read(rd_addr, rd_size);
            else rData <= '0;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rReady) begin
            rd_state <= R_IDLE;
            rValid   <= 1'b0;
            arReady  <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
